// File: rtl/chu_vga_rect_pkg.sv
// Shared types for the rectangle overlay core: rect_t, register offsets and the shadow write helper.
// No timing of its own; the blink feature is selected in the core by RECT_BLINK_EN.
package chu_vga_rect_pkg;

  localparam int NUM_RECT  = 4;
  localparam int OUTLINE_W = 2;
  localparam int COLOR_W   = 12;
  localparam int COORD_W   = 11;

  localparam logic [1:0] REG_XB     = 2'd0;
  localparam logic [1:0] REG_YB     = 2'd1;
  localparam logic [1:0] REG_ATTR   = 2'd2;
  localparam logic [4:0] REG_GLOBAL = 5'd16;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
    logic [COLOR_W-1:0] color;
    logic               en;
    logic               blink;
    logic               outline;
  } rect_t;

  // Applies one register-word write to a shadow rectangle; word 3 leaves it unchanged.
  function automatic rect_t rect_write(input rect_t r, input logic [1:0] field,
                                       input logic [31:0] d);
    rect_t n;
    n = r;
    case (field)
      REG_XB: begin
        n.x0 = d[10:0];
        n.x1 = d[26:16];
      end
      REG_YB: begin
        n.y0 = d[10:0];
        n.y1 = d[26:16];
      end
      REG_ATTR: begin
        n.color   = d[COLOR_W-1:0];
        n.en      = d[16];
        n.blink   = d[17];
        n.outline = d[18];
      end
      default: n = r;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/chu_vga_rect_if.sv
// Slot register write bus of the overlay core (write-only, no stall, no read-back).
interface chu_vga_rect_if;

  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;

  modport master (output cs, output write, output addr, output wr_data);
  modport slave  (input  cs, input  write, input  addr, input  wr_data);

endinterface

// File: rtl/chu_vga_rect_hit.sv
// Combinational filled/outline hit test of one rectangle against the current pixel.
// Zero latency; no flow control.
module chu_vga_rect_hit
  import chu_vga_rect_pkg::*;
#(
  parameter int OUTLINE_W = chu_vga_rect_pkg::OUTLINE_W
) (
  input  rect_t       rect,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        hit
);

  logic [11:0] xe, ye, x0e, x1e, y0e, y1e, ow;
  logic        in_fill, on_edge;
  logic        unused_attr;

  assign unused_attr = ^{rect.color, rect.en, rect.blink};

  // x > x1-W is evaluated as x+W > x1 so a narrow rect never underflows.
  always_comb begin
    xe  = {1'b0, x};
    ye  = {1'b0, y};
    x0e = {1'b0, rect.x0};
    x1e = {1'b0, rect.x1};
    y0e = {1'b0, rect.y0};
    y1e = {1'b0, rect.y1};
    ow  = 12'(OUTLINE_W);
    in_fill = (x0e <= xe) && (xe <= x1e) && (y0e <= ye) && (ye <= y1e);
    on_edge = (xe < x0e + ow) || (xe + ow > x1e) ||
              (ye < y0e + ow) || (ye + ow > y1e);
    hit = in_fill && (!rect.outline || on_edge);
  end

endmodule

// File: rtl/chu_vga_rect_core.sv
// Overlays up to four double-buffered rectangles on the pixel stream; so_rgb is valid 2 cycles after x,y,
// no backpressure (writes never stall). Blink counter/phase/period exist only with RECT_BLINK_EN defined.
module chu_vga_rect_core
  import chu_vga_rect_pkg::*;
#(
  parameter int CD        = 12,
  parameter int NUM_RECT  = chu_vga_rect_pkg::NUM_RECT,
  parameter int OUTLINE_W = chu_vga_rect_pkg::OUTLINE_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  chu_vga_rect_if.slave bus,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  rect_t shadow_rect [NUM_RECT];
  rect_t active_rect [NUM_RECT];
  logic  shadow_bypass, active_bypass;

  logic [10:0] x_prev, y_prev;
  logic        frame_start;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic        phase;
  logic        unused_addr;

  logic [NUM_RECT-1:0] hit_raw, vis_hit, vis_hit_q;
  logic [CD-1:0]       color_q [NUM_RECT];
  logic                bypass_q;
  logic [CD-1:0]       pix_nxt;

  assign wr_en       = bus.cs & bus.write;
  assign wr_idx      = bus.addr[3:2];
  assign unused_addr = ^bus.addr[13:5];

  // One event per frame: origin reached from anywhere else, so a stall at (0,0) counts once.
  assign frame_start = (x == 11'd0) && (y == 11'd0) &&
                       !((x_prev == 11'd0) && (y_prev == 11'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev <= '0;
      y_prev <= '0;
    end else begin
      x_prev <= x;
      y_prev <= y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RECT; i++) shadow_rect[i] <= '0;
      shadow_bypass <= 1'b0;
    end else if (wr_en) begin
      if (!bus.addr[4])
        shadow_rect[wr_idx] <= rect_write(shadow_rect[wr_idx], bus.addr[1:0], bus.wr_data);
      else if (bus.addr[4:0] == REG_GLOBAL)
        shadow_bypass <= bus.wr_data[8];
    end
  end

  // Commit on the event edge itself, so pixel (1,0) already sees the new set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RECT; i++) active_rect[i] <= '0;
      active_bypass <= 1'b0;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_RECT; i++) active_rect[i] <= shadow_rect[i];
      active_bypass <= shadow_bypass;
    end
  end

`ifdef RECT_BLINK_EN
  logic [7:0] shadow_period, active_period, blink_cnt;
  logic       phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_period <= '0;
      active_period <= '0;
    end else begin
      if (wr_en && bus.addr[4:0] == REG_GLOBAL) shadow_period <= bus.wr_data[7:0];
      if (frame_start) active_period <= shadow_period;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      phase_q   <= 1'b1;
    end else if (frame_start) begin
      if (active_period == 8'd0) begin
        blink_cnt <= '0;
        phase_q   <= 1'b1;
      end else if (blink_cnt == active_period - 8'd1) begin
        blink_cnt <= '0;
        phase_q   <= ~phase_q;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  assign phase = phase_q | (active_period == 8'd0);
`else
  assign phase = 1'b1;
`endif

  for (genvar i = 0; i < NUM_RECT; i++) begin : g_hit
    chu_vga_rect_hit #(.OUTLINE_W(OUTLINE_W)) u_hit (
      .rect (active_rect[i]),
      .x    (x),
      .y    (y),
      .hit  (hit_raw[i])
    );
  end

  always_comb begin
    vis_hit = '0;
    for (int i = 0; i < NUM_RECT; i++)
      vis_hit[i] = hit_raw[i] & active_rect[i].en & (~active_rect[i].blink | phase);
  end

  // Colours travel with the flags so the origin pixel never mixes old hits with new colours.
  always_ff @(posedge clk) begin
    if (reset) begin
      vis_hit_q <= '0;
      bypass_q  <= 1'b0;
      for (int i = 0; i < NUM_RECT; i++) color_q[i] <= '0;
    end else begin
      vis_hit_q <= vis_hit;
      bypass_q  <= active_bypass;
      for (int i = 0; i < NUM_RECT; i++) color_q[i] <= active_rect[i].color[CD-1:0];
    end
  end

  // si_rgb arrives one cycle behind its x,y and meets the stage-1 flags here.
  always_comb begin
    pix_nxt = si_rgb;
    if (!bypass_q) begin
      for (int i = NUM_RECT - 1; i >= 0; i--)
        if (vis_hit_q[i]) pix_nxt = color_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) so_rgb <= '0;
    else       so_rgb <= pix_nxt;
  end

endmodule
